// File: rtl/sldma350_trig_arbiter.sv
// Round-robin arbiter that shares one DMA-350 trigger-in port between NUM_REQ peripherals.
// Uses 4-phase req/ack handshakes on both sides, with registered outputs and a completed-trigger counter.
module sldma350_trig_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                 SYS_HCLK,
  input  logic                 SYS_HRESETn,
  input  logic                 ARB_EN,
  input  logic [NUM_REQ-1:0]   PERIPH_REQ,
  input  logic [2*NUM_REQ-1:0] PERIPH_REQ_TYPE,
  output logic [NUM_REQ-1:0]   PERIPH_ACK,
  output logic [1:0]           PERIPH_ACK_TYPE,
  output logic                 DMAC_TRIG_REQ,
  output logic [1:0]           DMAC_TRIG_REQ_TYPE,
  input  logic                 DMAC_TRIG_ACK,
  input  logic [1:0]           DMAC_TRIG_ACK_TYPE,
  output logic                 GRANT_VALID,
  output logic [ID_W-1:0]      GRANT_ID,
  output logic [CNT_W-1:0]     TRIG_COUNT
);

  typedef enum logic [1:0] {IDLE = 2'd0, DREQ = 2'd1, PACK = 2'd2} state_e;

  state_e               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      gnt_q, gnt_d;
  logic                 dreq_q, dreq_d;
  logic [1:0]           dtype_q, dtype_d;
  logic [NUM_REQ-1:0]   pack_q, pack_d;
  logic [1:0]           patype_q, patype_d;
  logic                 gv_q, gv_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ack_q;

  logic [2*NUM_REQ-1:0] dbl_s;
  logic [NUM_REQ-1:0]   rot_s;
  logic [ID_W-1:0]      off_s;
  logic [ID_W:0]        sum_s;
  logic [ID_W-1:0]      pick_s;
  logic [2*NUM_REQ-1:0] tshift_s;
  logic [NUM_REQ-1:0]   rshift_s;
  logic                 req_g_s;
  logic [ID_W-1:0]      ptr_next_s;
  logic [NUM_REQ-1:0]   onehot_s;

  // Rotating the request vector by ptr turns the round-robin search into a lowest-set-bit search.
  assign dbl_s      = {PERIPH_REQ, PERIPH_REQ} >> ptr_q;
  assign rot_s      = dbl_s[NUM_REQ-1:0];
  assign sum_s      = {1'b0, ptr_q} + {1'b0, off_s};
  assign pick_s     = (sum_s >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum_s - (ID_W+1)'(NUM_REQ))
                                                    : sum_s[ID_W-1:0];
  assign tshift_s   = PERIPH_REQ_TYPE >> {pick_s, 1'b0};
  assign rshift_s   = PERIPH_REQ >> gnt_q;
  assign req_g_s    = rshift_s[0];
  assign ptr_next_s = (gnt_q == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : gnt_q + {{(ID_W-1){1'b0}}, 1'b1};
  assign onehot_s   = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_q;

  // Lowest set bit of the rotated request vector
  always_comb begin
    off_s = {ID_W{1'b0}};
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        off_s = ID_W'(i);
      end else begin
        off_s = off_s;
      end
    end
  end

  // Next-state and next-output logic for the IDLE/DREQ/PACK handshake FSM
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    dreq_d   = dreq_q;
    dtype_d  = dtype_q;
    pack_d   = pack_q;
    patype_d = patype_q;
    gv_d     = gv_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (ARB_EN && (|PERIPH_REQ)) begin
          state_d = DREQ;
          gnt_d   = pick_s;
          gv_d    = 1'b1;
          dreq_d  = 1'b1;
          dtype_d = tshift_s[1:0];
        end else begin
          state_d = IDLE;
        end
      end
      DREQ: begin
        // Only a fresh rising ack counts; a level left over from earlier is ignored.
        if (DMAC_TRIG_ACK && !ack_q) begin
          state_d  = PACK;
          dreq_d   = 1'b0;
          pack_d   = onehot_s;
          patype_d = DMAC_TRIG_ACK_TYPE;
        end else begin
          state_d = DREQ;
        end
      end
      PACK: begin
        if (!req_g_s && !DMAC_TRIG_ACK) begin
          state_d = IDLE;
          pack_d  = {NUM_REQ{1'b0}};
          gv_d    = 1'b0;
          ptr_d   = ptr_next_s;
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          state_d = PACK;
        end
      end
      default: begin
        state_d = IDLE;
        dreq_d  = 1'b0;
        pack_d  = {NUM_REQ{1'b0}};
        gv_d    = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge SYS_HCLK or negedge SYS_HRESETn) begin
    if (!SYS_HRESETn) begin
      state_q  <= IDLE;
      ptr_q    <= {ID_W{1'b0}};
      gnt_q    <= {ID_W{1'b0}};
      dreq_q   <= 1'b0;
      dtype_q  <= 2'b00;
      pack_q   <= {NUM_REQ{1'b0}};
      patype_q <= 2'b00;
      gv_q     <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      dreq_q   <= dreq_d;
      dtype_q  <= dtype_d;
      pack_q   <= pack_d;
      patype_q <= patype_d;
      gv_q     <= gv_d;
      cnt_q    <= cnt_d;
      ack_q    <= DMAC_TRIG_ACK;
    end
  end

  assign PERIPH_ACK         = pack_q;
  assign PERIPH_ACK_TYPE    = patype_q;
  assign DMAC_TRIG_REQ      = dreq_q;
  assign DMAC_TRIG_REQ_TYPE = dtype_q;
  assign GRANT_VALID        = gv_q;
  assign GRANT_ID           = gnt_q;
  assign TRIG_COUNT         = cnt_q;

endmodule
